poly_mul_seq: RTL and testbench
===============================

POLY_MUL_SEQ -- requirements
Module: poly_mul_seq

Interface
REQ-001 SHALL have parameter N, default 4, meaning polynomial degree+1 (coefficients per operand, CSR depth).
REQ-002 SHALL have parameter CW, default 2, meaning step counter width (ceil(log2 N)).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request a multiply; sampled with in_data0/in_data1.
REQ-006 SHALL have port in_data0  input  N  operand coefficient bit-plane 0 (bit k = LSB of coef k).
REQ-007 SHALL have port in_data1  input  N  operand coefficient bit-plane 1 (bit k = MSB of coef k).
REQ-008 SHALL have port abort  input  1  synchronous cancel of the current operation.
REQ-009 SHALL have port res_ready  input  1  downstream accepts the result.
REQ-010 SHALL have port csr_data0  output  N  latched plane 0, drives the CSR load data.
REQ-011 SHALL have port csr_data1  output  N  latched plane 1, drives the CSR load data.
REQ-012 SHALL have port csr_load  output  1  CSR load strobe (CSR rotates when low).
REQ-013 SHALL have port mac_clr  output  1  clear accumulator.
REQ-014 SHALL have port mac_en  output  1  accumulate enable for current step.
REQ-015 SHALL have port step  output  CW  index of current rotation step.
REQ-016 SHALL have port busy  output  1  high in any state except IDLE.
REQ-017 SHALL have port res_valid  output  1  accumulator result is valid.
REQ-018 SHALL have port err_start  output  1  one-cycle pulse: start rejected.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD, RUN, WAIT; all outputs decoded from registered state/counters (Moore).
REQ-020 SHALL, in IDLE with start=1, latch in_data0/in_data1 into csr_data0/csr_data1 and go to LOAD next edge.
REQ-021 SHALL, in LOAD (exactly 1 cycle), drive csr_load=1, mac_clr=1, mac_en=0, step=0, then enter RUN.
REQ-022 SHALL, in RUN, drive csr_load=0, mac_en=1, step counting 0,1,...,N-1, one increment per cycle, exactly N cycles.
REQ-023 SHALL leave RUN for WAIT on the edge where step=N-1; step SHALL reset to 0 on that edge, never wrap within RUN.
REQ-024 SHALL, in WAIT, hold res_valid=1, mac_en=0, csr_data stable until res_ready=1.
REQ-025 SHALL, in WAIT with res_ready=1 and start=0, return to IDLE; with res_ready=1 and start=1, latch new operands and go directly to LOAD.
REQ-026 SHALL give latency: start accepted at edge t -> LOAD cycle t+1, RUN cycles t+2..t+N+1, res_valid first high at t+N+2.
REQ-027 SHALL ignore start in LOAD, RUN, and in WAIT with res_ready=0; such start SHALL pulse err_start for one cycle on the following cycle and leave csr_data unchanged.
REQ-028 SHALL, on abort=1 in any state, go to IDLE next edge, step=0, res_valid=0; abort SHALL take priority over start and res_ready in the same cycle.
REQ-029 SHALL hold csr_data0/csr_data1 constant from acceptance until next accepted start.
REQ-030 SHALL drive mac_clr=0 and csr_load=0 in all states other than LOAD.

Reset
REQ-031 SHALL, while reset=0, asynchronously force state IDLE, step=0, csr_data0=0, csr_data1=0, csr_load=0, mac_clr=0, mac_en=0, busy=0, res_valid=0, err_start=0.
REQ-032 SHALL, on reset asserted mid-RUN or mid-WAIT, discard the operation; after release no res_valid until a new start completes.
REQ-033 SHALL accept a start on the first rising edge after reset deasserts.

Verification
REQ-034 Single op: N=4, start with in_data0=4'b1010, in_data1=4'b0110, res_ready=1 -> csr_load 1 cycle, mac_en 4 cycles with step 0,1,2,3, res_valid at t+6 for 1 cycle, csr_data0=1010, csr_data1=0110.
REQ-035 Backpressure: res_ready=0 for 5 cycles after res_valid -> res_valid held 5+ cycles, busy=1, mac_en=0, operands unchanged.
REQ-036 Back-to-back: start=1 with res_ready=1 in WAIT, new data 4'b0001/4'b1111 -> next cycle LOAD, no IDLE cycle, csr_data updated.
REQ-037 Rejected start: start pulse at RUN step=1 -> err_start high exactly one cycle, step sequence and csr_data unchanged.
REQ-038 Abort: abort at RUN step=2 simultaneous with start -> IDLE next cycle, busy=0, res_valid never asserted, start not accepted.
REQ-039 Async reset: reset=0 mid-RUN between edges -> all outputs to reset values immediately; after release, start completes normally.

Source files
------------

// File: rtl/poly_mul_seq.sv
// Purpose : sequencer for a bit-serial polynomial multiply; latches two coefficient
//           bit-planes, loads the CSR, steps the MAC through N rotations, holds the result.
// Latency : start accepted at edge t -> LOAD t+1, RUN t+2..t+N+1, res_valid from t+N+2.
// Backpr. : res_valid/busy held in WAIT until res_ready; starts outside IDLE/ready-WAIT
//           are dropped and flagged on err_start.
//
// Ports
//   clk, reset          : clock, asynchronous active-low reset
//   start, in_data0/1   : operation request with operand bit-planes (bit k = coef k)
//   abort               : synchronous cancel, highest priority
//   res_ready           : downstream accepts the result held in WAIT
//   csr_data0/1         : latched operand planes (CSR load data)
//   csr_load, mac_clr   : CSR load strobe and accumulator clear (LOAD only)
//   mac_en, step        : accumulate enable and rotation index (RUN only)
//   busy, res_valid     : not IDLE / result available (WAIT)
//   err_start           : one-cycle pulse after a rejected start

module poly_mul_seq #(
    parameter int N  = 4,
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [N-1:0]  in_data0,
    input  logic [N-1:0]  in_data1,
    input  logic          abort,
    input  logic          res_ready,
    output logic [N-1:0]  csr_data0,
    output logic [N-1:0]  csr_data1,
    output logic          csr_load,
    output logic          mac_clr,
    output logic          mac_en,
    output logic [CW-1:0] step,
    output logic          busy,
    output logic          res_valid,
    output logic          err_start
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_step;
    logic [CW-1:0] w_step_nxt;
    logic [N-1:0]  r_csr_data0;
    logic [N-1:0]  r_csr_data1;
    logic          r_err_start;
    logic          w_accept;
    logic          w_reject;
    logic          w_last_step;

    assign w_last_step = (r_step == CW'(N - 1));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. Abort is applied last so it overrides any accept or
    // reject decision made by the state-specific branches.
    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = '0;
        w_accept    = 1'b0;
        w_reject    = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_reject    = start;
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                w_reject = start;
                // Step returns to 0 on the exit edge; it never wraps inside RUN.
                if (w_last_step) begin
                    w_state_nxt = S_WAIT;
                end else begin
                    w_step_nxt = r_step + CW'(1);
                end
            end
            S_WAIT: begin
                if (res_ready) begin
                    if (start) begin
                        // Back-to-back: skip IDLE and load the new operands directly.
                        w_accept    = 1'b1;
                        w_state_nxt = S_LOAD;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_reject = start;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (abort) begin
            w_state_nxt = S_IDLE;
            w_step_nxt  = '0;
            w_accept    = 1'b0;
            w_reject    = 1'b0;
        end
    end

    // Step counter, operand latch and error pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_step      <= '0;
            r_csr_data0 <= '0;
            r_csr_data1 <= '0;
            r_err_start <= 1'b0;
        end else begin
            r_step      <= w_step_nxt;
            r_err_start <= w_reject;
            if (w_accept) begin
                r_csr_data0 <= in_data0;
                r_csr_data1 <= in_data1;
            end
        end
    end

    // Moore outputs decoded from registered state
    assign csr_data0 = r_csr_data0;
    assign csr_data1 = r_csr_data1;
    assign csr_load  = (r_state == S_LOAD);
    assign mac_clr   = (r_state == S_LOAD);
    assign mac_en    = (r_state == S_RUN);
    assign step      = r_step;
    assign busy      = (r_state != S_IDLE);
    assign res_valid = (r_state == S_WAIT);
    assign err_start = r_err_start;

endmodule

// File: tb/tb_poly_mul_seq.sv
// Bench for poly_mul_seq: fixed single-operation table, hand sequences for
// backpressure, back-to-back, rejected start, abort and async reset, then a
// randomized run compared every cycle against an age-based operation model.

module tb_poly_mul_seq;

    localparam int N  = 4;
    localparam int CW = 2;

    logic          clk;
    logic          reset;
    logic          start;
    logic [N-1:0]  in_data0;
    logic [N-1:0]  in_data1;
    logic          abort;
    logic          res_ready;
    logic [N-1:0]  csr_data0;
    logic [N-1:0]  csr_data1;
    logic          csr_load;
    logic          mac_clr;
    logic          mac_en;
    logic [CW-1:0] step;
    logic          busy;
    logic          res_valid;
    logic          err_start;

    int checks   = 0;
    int failures = 0;

    // Model: an operation is "active" with an age counted in cycles since it
    // was accepted. Age 1 = load cycle, ages 2..N+1 = rotation steps,
    // age N+2 = result held until taken.
    bit           m_active;
    int           m_age;
    logic [N-1:0] m_d0;
    logic [N-1:0] m_d1;
    bit           m_err;

    typedef struct {
        bit           s;
        bit           a;
        bit           r;
        logic [N-1:0] d0;
        logic [N-1:0] d1;
        bit           load;
        bit           clr;
        bit           en;
        int           stp;
        bit           bsy;
        bit           vld;
        bit           err;
        logic [N-1:0] c0;
        logic [N-1:0] c1;
    } vec_t;

    vec_t tbl [7];

    poly_mul_seq #(.N(N), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_data0  (in_data0),
        .in_data1  (in_data1),
        .abort     (abort),
        .res_ready (res_ready),
        .csr_data0 (csr_data0),
        .csr_data1 (csr_data1),
        .csr_load  (csr_load),
        .mac_clr   (mac_clr),
        .mac_en    (mac_en),
        .step      (step),
        .busy      (busy),
        .res_valid (res_valid),
        .err_start (err_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_age    = 0;
        m_d0     = '0;
        m_d1     = '0;
        m_err    = 1'b0;
    endtask

    task automatic model_edge(input bit s, input bit a, input bit r,
                              input logic [N-1:0] x0, input logic [N-1:0] x1);
        m_err = 1'b0;
        if (a) begin
            m_active = 1'b0;
            m_age    = 0;
        end else if (!m_active) begin
            if (s) begin
                m_active = 1'b1;
                m_age    = 1;
                m_d0     = x0;
                m_d1     = x1;
            end
        end else if (m_age >= N + 2) begin
            if (r) begin
                if (s) begin
                    m_age = 1;
                    m_d0  = x0;
                    m_d1  = x1;
                end else begin
                    m_active = 1'b0;
                    m_age    = 0;
                end
            end else if (s) begin
                m_err = 1'b1;
            end
        end else begin
            if (s) m_err = 1'b1;
            m_age++;
        end
    endtask

    task automatic check_model(input string tag);
        bit en;
        int st;
        en = m_active && (m_age >= 2) && (m_age <= N + 1);
        st = en ? (m_age - 2) : 0;
        chk({tag, ".csr_load"},  32'(csr_load),  32'(m_active && m_age == 1));
        chk({tag, ".mac_clr"},   32'(mac_clr),   32'(m_active && m_age == 1));
        chk({tag, ".mac_en"},    32'(mac_en),    32'(en));
        chk({tag, ".step"},      32'(step),      32'(st));
        chk({tag, ".busy"},      32'(busy),      32'(m_active));
        chk({tag, ".res_valid"}, 32'(res_valid), 32'(m_active && m_age >= N + 2));
        chk({tag, ".err_start"}, 32'(err_start), 32'(m_err));
        chk({tag, ".csr_data0"}, 32'(csr_data0), 32'(m_d0));
        chk({tag, ".csr_data1"}, 32'(csr_data1), 32'(m_d1));
    endtask

    // Drive inputs, take one rising edge, sample 1 ns later against the model.
    task automatic tick(input bit s, input bit a, input bit r,
                        input logic [N-1:0] x0, input logic [N-1:0] x1, input string tag);
        start     = s;
        abort     = a;
        res_ready = r;
        in_data0  = x0;
        in_data1  = x1;
        @(posedge clk);
        model_edge(s, a, r, x0, x1);
        #1;
        check_model(tag);
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        res_ready = 1'b0;
        in_data0  = '0;
        in_data1  = '0;
        model_reset();

        // Single operation, N=4: expected outputs after each edge.
        tbl[0] = '{1'b1, 1'b0, 1'b1, 4'hA, 4'h6, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 4'hA, 4'h6};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 4'hA, 4'h6};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0, 4'hA, 4'h6};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b0, 4'hA, 4'h6};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 3, 1'b1, 1'b0, 1'b0, 4'hA, 4'h6};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 4'hA, 4'h6};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 4'hA, 4'h6};

        // Reset state, sampled between edges while reset is held low.
        #12;
        chk("rst.busy",      32'(busy),      32'd0);
        chk("rst.res_valid", 32'(res_valid), 32'd0);
        chk("rst.csr_data0", 32'(csr_data0), 32'd0);
        check_model("rst");
        @(negedge clk);
        reset = 1'b1;

        // Table: start accepted on the first edge after reset release.
        for (int i = 0; i < 7; i++) begin
            tick(tbl[i].s, tbl[i].a, tbl[i].r, tbl[i].d0, tbl[i].d1, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.load", i),  32'(csr_load),  32'(tbl[i].load));
            chk($sformatf("tbl%0d.clr", i),   32'(mac_clr),   32'(tbl[i].clr));
            chk($sformatf("tbl%0d.en", i),    32'(mac_en),    32'(tbl[i].en));
            chk($sformatf("tbl%0d.step", i),  32'(step),      32'(tbl[i].stp));
            chk($sformatf("tbl%0d.busy", i),  32'(busy),      32'(tbl[i].bsy));
            chk($sformatf("tbl%0d.valid", i), 32'(res_valid), 32'(tbl[i].vld));
            chk($sformatf("tbl%0d.err", i),   32'(err_start), 32'(tbl[i].err));
            chk($sformatf("tbl%0d.c0", i),    32'(csr_data0), 32'(tbl[i].c0));
            chk($sformatf("tbl%0d.c1", i),    32'(csr_data1), 32'(tbl[i].c1));
        end

        // Backpressure: result held while res_ready stays low.
        tick(1'b1, 1'b0, 1'b0, 4'hC, 4'h3, "bp.start");
        for (int i = 0; i < N + 1; i++) tick(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, "bp.run");
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, "bp.hold");
            chk("bp.res_valid", 32'(res_valid), 32'd1);
            chk("bp.busy",      32'(busy),      32'd1);
            chk("bp.mac_en",    32'(mac_en),    32'd0);
            chk("bp.csr_data0", 32'(csr_data0), 32'hC);
            chk("bp.csr_data1", 32'(csr_data1), 32'h3);
        end

        // Back-to-back: start with res_ready in the result cycle goes straight to load.
        tick(1'b1, 1'b0, 1'b1, 4'h1, 4'hF, "b2b");
        chk("b2b.csr_load",  32'(csr_load),  32'd1);
        chk("b2b.busy",      32'(busy),      32'd1);
        chk("b2b.csr_data0", 32'(csr_data0), 32'h1);
        chk("b2b.csr_data1", 32'(csr_data1), 32'hF);

        // Rejected start at step 1.
        tick(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, "rej.s0");
        tick(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, "rej.s1");
        chk("rej.step1", 32'(step), 32'd1);
        tick(1'b1, 1'b0, 1'b0, 4'hA, 4'h5, "rej.pulse");
        chk("rej.err_hi",    32'(err_start), 32'd1);
        chk("rej.step2",     32'(step),      32'd2);
        chk("rej.csr_data0", 32'(csr_data0), 32'h1);
        tick(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, "rej.after");
        chk("rej.err_lo", 32'(err_start), 32'd0);
        chk("rej.step3",  32'(step),      32'd3);
        tick(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, "rej.wait");
        tick(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, "rej.idle");

        // Abort at step 2 together with a start.
        tick(1'b1, 1'b0, 1'b1, 4'h6, 4'h9, "ab.start");
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, "ab.run");
        chk("ab.step2", 32'(step), 32'd2);
        tick(1'b1, 1'b1, 1'b1, 4'hF, 4'hF, "ab.abort");
        chk("ab.busy",      32'(busy),      32'd0);
        chk("ab.res_valid", 32'(res_valid), 32'd0);
        chk("ab.csr_data0", 32'(csr_data0), 32'h6);
        for (int i = 0; i < N + 2; i++) begin
            tick(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, "ab.idle");
            chk("ab.no_valid", 32'(res_valid), 32'd0);
        end

        // Asynchronous reset between edges mid-run.
        tick(1'b1, 1'b0, 1'b1, 4'h5, 4'hA, "ar.start");
        tick(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, "ar.s0");
        tick(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, "ar.s1");
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk("ar.busy",      32'(busy),      32'd0);
        chk("ar.mac_en",    32'(mac_en),    32'd0);
        chk("ar.step",      32'(step),      32'd0);
        chk("ar.csr_data1", 32'(csr_data1), 32'd0);
        check_model("ar.low");
        @(negedge clk);
        reset = 1'b1;
        tick(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, "ar.idle");
        tick(1'b1, 1'b0, 1'b1, 4'h3, 4'hC, "ar.restart");
        for (int i = 0; i < N + 2; i++) tick(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, "ar.run");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 5),
                 ($urandom_range(0, 99) < 60),
                 N'($urandom), N'($urandom), "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
